prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Parametrised UART-fed memory programming engine for the Ghazi Caravel wrapper.
- Receives framed byte packets from the UART receiver and streams words into one of NUM_REGIONS on-chip RAMs (instruction, data, ...).
- Owns the core reset: the core is held in reset until a BOOT command arrives.
- Adds region select, explicit addressing, checksum, inter-byte timeout and error reporting.

Parameters:
- AW, 14, word address width of every region (1..16).
- DW, 32, word width in bits; multiple of 8, 8..32.
- NUM_REGIONS, 2, number of target memories (1..4).
- TIMEOUT_CYCLES, 1000000, max clocks between bytes inside a frame before abort.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- rx_dv_i  in  1  one-cycle strobe, byte valid from UART receiver.
- rx_byte_i  in  8  received byte.
- mem_we_o  out  NUM_REGIONS  one-hot write strobe per region.
- mem_addr_o  out  AW  word address, shared by all regions.
- mem_wdata_o  out  DW  write data, shared by all regions.
- core_rst_no  out  1  active-low core reset.
- busy_o  out  1  high while a frame is in progress.
- err_o  out  2  [0] checksum error, [1] protocol error (bad command, bad region, timeout, write while running).

Behaviour:
- Reset is synchronous and active-high; all state is clocked on wb_clk_i.
- Reset values: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_no=0, busy_o=0, err_o=0, FSM=IDLE.
- Frame format (all bytes delivered on rx_dv_i):
  - CMD byte.
  - ADDR_LO, ADDR_HI: word address, little-endian; bits above AW are ignored.
  - LEN: word count N; a value of 0 means 256.
  - N*(DW/8) data bytes, little-endian within each word.
  - CSUM byte: the 8-bit sum of every byte from CMD through CSUM must equal 0x00.
- Commands:
  - 0x5r (r = region 0..3) starts a write frame.
  - 0xF0 = BOOT: core_rst_no goes to 1 the cycle after the strobe.
  - 0xF1 = HALT: core_rst_no goes to 0 the cycle after the strobe.
  - Any other byte in IDLE sets err_o[1] and stays in IDLE.
- Write-frame command rejection: if r >= NUM_REGIONS or core_rst_no=1, set err_o[1], stay in IDLE and ignore the frame bytes. The following bytes are parsed as commands, so invalid ones raise err_o[1] again.
- FSM states: IDLE -> ADDR0 -> ADDR1 -> LEN -> DATA -> CSUM -> IDLE.
  - Each transition is taken on a rx_dv_i strobe.
  - DATA loops until N words are complete.
  - busy_o=1 in every state except IDLE.
- Accepting any valid CMD byte clears err_o.
- Write timing:
  - On the strobe that completes a word, the next cycle drives mem_we_o[r]=1 for exactly one cycle, with mem_addr_o/mem_wdata_o valid in that same cycle.
  - After each write, the address increments and wraps modulo 2^AW.
  - Writes are streamed, not buffered. A checksum failure is flagged only, via err_o[0] set the cycle after the CSUM strobe; already-written words are not undone.
- Timeout:
  - An inter-byte counter runs in every non-IDLE state and restarts on each strobe.
  - On reaching TIMEOUT_CYCLES: return to IDLE, set err_o[1], busy_o=0.
  - No partial-word write is issued.
- Simultaneous events: wb_rst_i has priority over rx_dv_i. Reset mid-frame discards the frame and re-asserts core reset.
- rx_dv_i is never asserted on two consecutive cycles; behaviour under back-to-back strobes is undefined.

Optional Feature:
- Macro: PROG_LOADER_ACK_EN.
- When defined, add outputs ack_valid_o (1) and ack_byte_o (8) for a UART transmitter:
  - One cycle after each frame ends, ack_valid_o pulses for one cycle.
  - ack_byte_o = 0x06 (ACK) for a good frame or accepted BOOT/HALT.
  - ack_byte_o = 0x15 (NAK) for a checksum error, protocol error or timeout.
  - Reset values: ack_valid_o=0, ack_byte_o=0.
- When not defined, the ports do not exist and no ACK logic is built.

Test Plan:
- Reset then idle -> core_rst_no=0, mem_we_o=0, err_o=0, busy_o=0.
- Frame 0x51, 0x10, 0x00, 0x02, bytes 11 22 33 44 55 66 77 88, correct CSUM -> mem_we_o=2'b10 pulses twice:
  - addr 0x0010 data 0x44332211;
  - addr 0x0011 data 0x88776655;
  - then err_o=0, busy_o=0.
- Same frame with CSUM off by 1 -> both writes still occur, err_o=2'b01; with PROG_LOADER_ACK_EN, ack_byte_o=0x15.
- ADDR=0x3FFF, LEN=2 with AW=14 -> writes at 0x3FFF, then 0x0000.
- 0xF0 -> core_rst_no=1 next cycle; then 0x50 -> err_o=2'b10, no mem_we_o; then 0xF1 -> core_rst_no=0 and err_o cleared.
- Frame halted after 2 data bytes for TIMEOUT_CYCLES (set to 100) -> returns to IDLE, err_o[1]=1, no write; wb_rst_i asserted mid-frame -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: UART-fed memory programming engine.
//
// Parses framed byte packets from a UART receiver and streams little-endian
// words into one of NUM_REGIONS on-chip RAMs. Owns the core reset, which is
// held asserted until a BOOT command arrives.
//
// Frame: CMD, ADDR_LO, ADDR_HI, LEN (0 = 256 words), LEN*(DW/8) data bytes,
// CSUM (8-bit sum of all frame bytes including CSUM must be zero).
// Commands: 0x5r write to region r, 0xF0 BOOT, 0xF1 HALT.
//
// Ports:
//   wb_clk_i     system clock
//   wb_rst_i     synchronous active-high reset
//   rx_dv_i      one-cycle byte-valid strobe from the UART receiver
//   rx_byte_i    received byte
//   mem_we_o     one-hot write strobe, one bit per region
//   mem_addr_o   shared word address
//   mem_wdata_o  shared write data
//   core_rst_no  active-low core reset
//   busy_o       high while a frame is in progress
//   err_o        [0] checksum error, [1] protocol error
//   ack_valid_o  (PROG_LOADER_ACK_EN only) one-cycle pulse after a frame ends
//   ack_byte_o   (PROG_LOADER_ACK_EN only) 0x06 ACK / 0x15 NAK
//
// Optional feature macro: PROG_LOADER_ACK_EN adds the ACK/NAK outputs.

module prog_loader #(
    parameter int AW             = 14,
    parameter int DW             = 32,
    parameter int NUM_REGIONS    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   rx_dv_i,
    input  logic [7:0]             rx_byte_i,
    output logic [NUM_REGIONS-1:0] mem_we_o,
    output logic [AW-1:0]          mem_addr_o,
    output logic [DW-1:0]          mem_wdata_o,
    output logic                   core_rst_no,
    output logic                   busy_o,
    output logic [1:0]             err_o
`ifdef PROG_LOADER_ACK_EN
    ,
    output logic                   ack_valid_o,
    output logic [7:0]             ack_byte_o
`endif
);

    localparam int unsigned BYTES = DW / 8;
    localparam int          BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NR    = NUM_REGIONS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR0 = 3'd1;
    localparam logic [2:0] S_ADDR1 = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;

    logic [2:0]     state;
    logic [1:0]     region;
    logic [7:0]     addr_lo;
    logic [AW-1:0]  cur_addr;
    logic [8:0]     words_left;
    logic [BIW-1:0] byte_idx;
    logic [DW-1:0]  word_buf;
    logic [7:0]     csum;
    logic [TW-1:0]  timer;

    logic [DW-1:0]  next_word;
    logic [7:0]     csum_next;
    logic           last_byte;
    logic           is_boot;
    logic           is_halt;
    logic           write_ok;
    logic           timeout;

    // Word under assembly with the incoming byte merged into its lane.
    always_comb begin
        next_word = word_buf;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (byte_idx == BIW'(b)) begin
                next_word[b*8 +: 8] = rx_byte_i;
            end
        end
    end

    assign csum_next = csum + rx_byte_i;
    assign last_byte = (byte_idx == BIW'(BYTES - 1));
    assign is_boot   = (rx_byte_i == 8'hF0);
    assign is_halt   = (rx_byte_i == 8'hF1);
    // Writes are refused while the core runs so it never sees its memory change.
    assign write_ok  = (rx_byte_i[7:4] == 4'h5) && (32'(rx_byte_i[3:0]) < NR) && !core_rst_no;
    // A strobe in the same cycle as expiry wins; the byte is accepted.
    assign timeout   = (state != S_IDLE) && !rx_dv_i && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign busy_o    = (state != S_IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= S_IDLE;
            region      <= '0;
            addr_lo     <= '0;
            cur_addr    <= '0;
            words_left  <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            csum        <= '0;
            timer       <= '0;
            mem_we_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            core_rst_no <= 1'b0;
            err_o       <= '0;
        end else begin
            mem_we_o <= '0;

            if (rx_dv_i) begin
                timer <= '0;
            end else if (state != S_IDLE) begin
                timer <= timer + TW'(1);
            end

            if (timeout) begin
                state    <= S_IDLE;
                err_o[1] <= 1'b1;
            end else if (rx_dv_i) begin
                case (state)
                    S_IDLE: begin
                        if (is_boot) begin
                            core_rst_no <= 1'b1;
                            err_o       <= '0;
                        end else if (is_halt) begin
                            core_rst_no <= 1'b0;
                            err_o       <= '0;
                        end else if (write_ok) begin
                            region <= rx_byte_i[1:0];
                            csum   <= rx_byte_i;
                            err_o  <= '0;
                            state  <= S_ADDR0;
                        end else begin
                            err_o[1] <= 1'b1;
                        end
                    end
                    S_ADDR0: begin
                        addr_lo <= rx_byte_i;
                        csum    <= csum_next;
                        state   <= S_ADDR1;
                    end
                    S_ADDR1: begin
                        cur_addr <= AW'({rx_byte_i, addr_lo});
                        csum     <= csum_next;
                        state    <= S_LEN;
                    end
                    S_LEN: begin
                        words_left <= {(rx_byte_i == 8'h00), rx_byte_i};
                        byte_idx   <= '0;
                        csum       <= csum_next;
                        state      <= S_DATA;
                    end
                    S_DATA: begin
                        csum     <= csum_next;
                        word_buf <= next_word;
                        if (last_byte) begin
                            mem_we_o    <= NUM_REGIONS'(1) << region;
                            mem_addr_o  <= cur_addr;
                            mem_wdata_o <= next_word;
                            cur_addr    <= cur_addr + AW'(1);
                            byte_idx    <= '0;
                            if (words_left == 9'd1) begin
                                state <= S_CSUM;
                            end else begin
                                words_left <= words_left - 9'd1;
                            end
                        end else begin
                            byte_idx <= byte_idx + BIW'(1);
                        end
                    end
                    S_CSUM: begin
                        if (csum_next != 8'h00) begin
                            err_o[0] <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PROG_LOADER_ACK_EN
    logic frame_end;
    logic frame_nak;

    // A frame ends on CSUM, on any single-byte command outcome other than
    // starting a write, or on timeout.
    always_comb begin
        frame_end = 1'b0;
        frame_nak = 1'b0;
        if (timeout) begin
            frame_end = 1'b1;
            frame_nak = 1'b1;
        end else if (rx_dv_i) begin
            if (state == S_IDLE) begin
                if (is_boot || is_halt) begin
                    frame_end = 1'b1;
                end else if (!write_ok) begin
                    frame_end = 1'b1;
                    frame_nak = 1'b1;
                end
            end else if (state == S_CSUM) begin
                frame_end = 1'b1;
                frame_nak = (csum_next != 8'h00);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_valid_o <= 1'b0;
            ack_byte_o  <= '0;
        end else begin
            ack_valid_o <= frame_end;
            if (frame_end) begin
                ack_byte_o <= frame_nak ? 8'h15 : 8'h06;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (AW=14, DW=32, NUM_REGIONS=2,
// TIMEOUT_CYCLES=100). Expected writes come from a frame-level model that
// expands each frame into its list of (region, address, word) writes.

module tb_prog_loader;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 100;

    typedef struct packed {
        logic [NR-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = '0;
    logic [NR-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic [1:0]    err;
`ifdef PROG_LOADER_ACK_EN
    logic          ack_valid;
    logic [7:0]    ack_byte;
    logic [7:0]    ack_q[$];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wr_t        obs[$];
    wr_t        exp_q[$];
    logic [7:0] payload[$];

    prog_loader #(
        .AW(AW),
        .DW(DW),
        .NUM_REGIONS(NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .rx_dv_i(rx_dv),
        .rx_byte_i(rx_byte),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .core_rst_no(core_rst_n),
        .busy_o(busy),
        .err_o(err)
`ifdef PROG_LOADER_ACK_EN
        ,
        .ack_valid_o(ack_valid),
        .ack_byte_o(ack_byte)
`endif
    );

    always #5 clk = ~clk;

    // Every cycle with a write strobe is one observed write.
    always @(negedge clk) begin
        if (mem_we !== '0) obs.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
`ifdef PROG_LOADER_ACK_EN
        if (ack_valid === 1'b1) ack_q.push_back(ack_byte);
`endif
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends a write frame built from payload[], compares writes and err_o.
    task automatic run_frame(input string name, input int region, input int addr16,
                             input int len, input int csum_delta, input int maxgap);
        logic [7:0] frame[$];
        int         n;
        int         sum;
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        logic [1:0] exp_err;
        n = (len == 0) ? 256 : len;
        obs.delete();
        exp_q.delete();
`ifdef PROG_LOADER_ACK_EN
        ack_q.delete();
`endif
        frame.push_back(8'(8'h50 + region));
        frame.push_back(8'(addr16 & 255));
        frame.push_back(8'((addr16 >> 8) & 255));
        frame.push_back(8'(len));
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int k = 0; k < DW / 8; k++) begin
                w = w | (DW'(payload[i * (DW / 8) + k]) << (8 * k));
                frame.push_back(payload[i * (DW / 8) + k]);
            end
            a = AW'((addr16 + i) % (1 << AW));
            exp_q.push_back('{we: NR'(1 << region), addr: a, data: w});
        end
        sum = 0;
        foreach (frame[i]) sum += int'(frame[i]);
        frame.push_back(8'((512 - (sum % 256) + csum_delta) % 256));
        foreach (frame[i]) send_byte(frame[i], $urandom_range(1, maxgap));
        repeat (2) @(negedge clk);

        n_tests++;
        if (obs.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected %0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         name, i, obs[i].we, obs[i].addr, obs[i].data,
                         exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
        end
        exp_err = (csum_delta != 0) ? 2'b01 : 2'b00;
        n_tests++;
        if (err !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s status: got err=%b busy=%b expected err=%b busy=0", name, err, busy, exp_err);
        end
`ifdef PROG_LOADER_ACK_EN
        n_tests++;
        if (ack_q.size() != 1 || ack_q[0] !== ((csum_delta != 0) ? 8'h15 : 8'h06)) begin
            n_fail++;
            $display("FAIL %s ack: got %0d acks expected one %h", name, ack_q.size(),
                     (csum_delta != 0) ? 8'h15 : 8'h06);
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({core_rst_n, mem_we, err, busy, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset: got core=%b we=%b err=%b busy=%b addr=%h data=%h expected all zero",
                     core_rst_n, mem_we, err, busy, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_write;
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame("write_basic", 1, 16'h0010, 2, 0, 1);
        run_frame("csum_error", 1, 16'h0010, 2, 1, 1);
    endtask

    task automatic test_wrap;
        payload.delete();
        repeat (8) payload.push_back(8'($urandom));
        run_frame("addr_wrap", 0, 16'h3FFF, 2, 0, 2);
        run_frame("addr_high_ignored", 1, 16'hFFFE, 2, 0, 2);
    endtask

    task automatic test_len256;
        payload.delete();
        repeat (1024) payload.push_back(8'($urandom));
        run_frame("len_256", 0, 16'h3F80, 0, 0, 1);
    endtask

    task automatic test_random_frames;
        for (int t = 0; t < 8; t++) begin
            payload.delete();
            repeat (24) payload.push_back(8'($urandom));
            run_frame($sformatf("random_%0d", t), $urandom_range(0, NR - 1), $urandom & 16'hFFFF,
                      $urandom_range(1, 6), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 255) : 0, 4);
        end
    endtask

    task automatic test_boot_halt;
        obs.delete();
        send_byte(8'hF0, 0);
        n_tests++;
        if (core_rst_n !== 1'b1 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL boot: got core=%b err=%b expected core=1 err=00", core_rst_n, err);
        end
        send_byte(8'h50, 1);
        send_byte(8'h10, 1);
        repeat (2) @(negedge clk);
        n_tests++;
        if (err !== 2'b10 || busy !== 1'b0 || obs.size() != 0) begin
            n_fail++;
            $display("FAIL write_while_running: got err=%b busy=%b writes=%0d expected err=10 busy=0 writes=0",
                     err, busy, obs.size());
        end
        send_byte(8'hF1, 0);
        n_tests++;
        if (core_rst_n !== 1'b0 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL halt: got core=%b err=%b expected core=0 err=00", core_rst_n, err);
        end
    endtask

    task automatic test_bad_cmd;
        logic [7:0] bad[$];
        bad = '{8'h00, 8'h52, 8'h53, 8'h5F, 8'h4F, 8'hF2, 8'hFF};
        obs.delete();
        foreach (bad[i]) begin
            send_byte(bad[i], 1);
            n_tests++;
            if (err !== 2'b10 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_cmd_%h: got err=%b busy=%b expected err=10 busy=0", bad[i], err, busy);
            end
        end
        send_byte(8'hF1, 1);
        n_tests++;
        if (err !== 2'b00 || obs.size() != 0) begin
            n_fail++;
            $display("FAIL bad_cmd_clear: got err=%b writes=%0d expected err=00 writes=0", err, obs.size());
        end
    endtask

    task automatic test_timeout;
        obs.delete();
        send_byte(8'h50, 1);
        send_byte(8'h20, 1);
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 0);
        repeat (TO - 10) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_early: got busy=%b err=%b expected busy=1 err=00", busy, err);
        end
        repeat (15) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || err !== 2'b10 || obs.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: got busy=%b err=%b writes=%0d expected busy=0 err=10 writes=0",
                     busy, err, obs.size());
        end
    endtask

    task automatic test_reset_midframe;
        obs.delete();
        send_byte(8'h50, 1);
        send_byte(8'h23, 1);
        send_byte(8'h01, 1);
        send_byte(8'h03, 1);
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 1);
        send_byte(8'hBE, 1);
        send_byte(8'hEF, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 0);
        n_tests++;
        if (obs.size() != 1 || mem_addr !== 14'h0123 || mem_wdata !== 32'hEFBEADDE || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_pre: got writes=%0d addr=%h data=%h busy=%b expected 1 0123 efbeadde 1",
                     obs.size(), mem_addr, mem_wdata, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({core_rst_n, mem_we, err, busy, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got core=%b we=%b err=%b busy=%b addr=%h data=%h expected all zero",
                     core_rst_n, mem_we, err, busy, mem_addr, mem_wdata);
        end
        send_byte(8'hF0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (core_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after_boot: got core=%b expected 0", core_rst_n);
        end
        payload.delete();
        repeat (4) payload.push_back(8'($urandom));
        run_frame("after_reset", 1, 16'h0100, 1, 0, 2);
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrap();
        test_boot_halt();
        test_bad_cmd();
        test_random_frames();
        test_timeout();
        test_len256();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
